raster_traverser: RTL and testbench

RASTER_TRAVERSER -- requirements
Module: raster_traverser

---
 rtl/raster_traverser_pkg.sv | 23 ++
 rtl/raster_traverser_pix.sv | 37 +++
 rtl/raster_traverser.sv | 155 +++++++++++++++
 tb/tb_raster_traverser.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_traverser_pkg.sv
// Shared types and constants for the raster traverser: FSM encoding,
// recFN(8,24) field widths and the 66-bit {x,y} point layout.
package raster_traverser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int unsigned REC_EXP_W    = 9;
   localparam int unsigned REC_SIG_W    = 23;
   localparam int unsigned REC_W        = 1 + REC_EXP_W + REC_SIG_W;
   localparam int unsigned REC_EXP_BIAS = 256;
   localparam int unsigned PT_W         = 2 * REC_W;

   // A sample point: x in the upper half, y in the lower half
   typedef struct packed {
      logic [REC_W-1:0] x;
      logic [REC_W-1:0] y;
   } point_t;

endpackage

// File: rtl/raster_traverser_pix.sv
// Exact recFN(8,24) encoding of a pixel centre n+0.5, built from 2n+1.
module pix_to_recfn
   import raster_traverser_pkg::*;
#(
   parameter int unsigned COORD_W = 10
) (
   input  logic [COORD_W-1:0] n_i,
   output logic [REC_W-1:0]   rec_c_o
);

   localparam int unsigned V_W   = COORD_W + 1;
   localparam int unsigned POS_W = (V_W > 2) ? $clog2(V_W) : 1;

   logic [V_W-1:0]       v;
   logic [POS_W-1:0]     lead_pos;
   logic [4:0]           shamt;
   logic [REC_EXP_W-1:0] exp_rec;
   logic [REC_SIG_W-1:0] frac;

   // 2n+1 is odd, so it is never zero and always has a leading one
   assign v = {n_i, 1'b1};

   // Leading-one detector: highest set bit of 2n+1
   always_comb begin
      lead_pos = '0;
      for (int unsigned i = 0; i < V_W; i++) begin
         if (v[i]) lead_pos = POS_W'(i);
      end
   end

   // Shift the leading one just past the fraction field so it drops off
   assign shamt   = 5'(REC_SIG_W) - 5'(lead_pos);
   assign frac    = REC_SIG_W'(v) << shamt;
   assign exp_rec = REC_EXP_W'(REC_EXP_BIAS - 1) + REC_EXP_W'(lead_pos);
   assign rec_c_o = {1'b0, exp_rec, frac};

endmodule

// File: rtl/raster_traverser.sv
// Walks a triangle's pixel bounding box in x-major order, presents each
// pixel centre to an external point sampler and streams covered pixels.
module raster_traverser
   import raster_traverser_pkg::*;
#(
   parameter int unsigned COORD_W = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tri_valid,
   output logic               tri_ready,
   input  logic [COORD_W-1:0] bb_xmin,
   input  logic [COORD_W-1:0] bb_xmax,
   input  logic [COORD_W-1:0] bb_ymin,
   input  logic [COORD_W-1:0] bb_ymax,
   input  logic [PT_W-1:0]    tri_pa,
   input  logic [PT_W-1:0]    tri_pb,
   input  logic [PT_W-1:0]    tri_pc,
   input  logic               tri_winding,
   output logic [PT_W-1:0]    samp_pa,
   output logic [PT_W-1:0]    samp_pb,
   output logic [PT_W-1:0]    samp_pc,
   output logic               samp_winding,
   output logic [PT_W-1:0]    samp_p,
   input  logic               samp_inside,
   output logic               frag_valid,
   input  logic               frag_ready,
   output logic [COORD_W-1:0] frag_x,
   output logic [COORD_W-1:0] frag_y,
   output logic               done
);

   state_e               state_q;
   logic                 tri_ready_q;
   logic                 done_q;
   logic                 frag_valid_q;
   logic                 winding_q;
   logic [PT_W-1:0]      pa_q, pb_q, pc_q;
   logic [COORD_W-1:0]   cur_x_q, cur_y_q;
   logic [COORD_W-1:0]   xmin_q, xmax_q, ymax_q;
   logic [COORD_W-1:0]   frag_x_q, frag_y_q;
   logic [COORD_W-1:0]   cur_x_d, cur_y_d;

   logic                 scan_c, stall_c, advance_c, load_c, accept_c;
   logic                 row_end_c, box_end_c, box_empty_c;
   logic [REC_W-1:0]     conv_x_c, conv_y_c;
   point_t               samp_pt_c;

   assign scan_c      = (state_q == ST_SCAN);
   assign accept_c    = frag_valid_q && frag_ready;
   assign stall_c     = samp_inside && frag_valid_q && !frag_ready;
   assign advance_c   = scan_c && !stall_c;
   assign load_c      = advance_c && samp_inside;
   assign row_end_c   = (cur_x_q == xmax_q);
   assign box_end_c   = row_end_c && (cur_y_q == ymax_q);
   assign box_empty_c = (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax);

   // Pixel-centre coordinates of the current sample
   pix_to_recfn #(.COORD_W(COORD_W)) u_conv_x (.n_i(cur_x_q), .rec_c_o(conv_x_c));
   pix_to_recfn #(.COORD_W(COORD_W)) u_conv_y (.n_i(cur_y_q), .rec_c_o(conv_y_c));

   assign samp_pt_c = '{x: conv_x_c, y: conv_y_c};
   assign samp_p    = scan_c ? samp_pt_c : '0;

   // Next raster position; equality compares keep the max coordinate safe
   always_comb begin
      cur_x_d = cur_x_q + COORD_W'(1);
      cur_y_d = cur_y_q;
      if (row_end_c) begin
         cur_x_d = xmin_q;
         cur_y_d = cur_y_q + COORD_W'(1);
      end
   end

   // Control FSM, scan counters, triangle latch and fragment register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tri_ready_q  <= 1'b1;
         done_q       <= 1'b0;
         frag_valid_q <= 1'b0;
         winding_q    <= 1'b0;
         pa_q         <= '0;
         pb_q         <= '0;
         pc_q         <= '0;
         cur_x_q      <= '0;
         cur_y_q      <= '0;
         xmin_q       <= '0;
         xmax_q       <= '0;
         ymax_q       <= '0;
         frag_x_q     <= '0;
         frag_y_q     <= '0;
      end else begin
         done_q <= 1'b0;

         if (load_c) begin
            frag_valid_q <= 1'b1;
            frag_x_q     <= cur_x_q;
            frag_y_q     <= cur_y_q;
         end else if (accept_c) begin
            frag_valid_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (tri_valid && tri_ready_q) begin
                  pa_q        <= tri_pa;
                  pb_q        <= tri_pb;
                  pc_q        <= tri_pc;
                  winding_q   <= tri_winding;
                  xmin_q      <= bb_xmin;
                  xmax_q      <= bb_xmax;
                  ymax_q      <= bb_ymax;
                  cur_x_q     <= bb_xmin;
                  cur_y_q     <= bb_ymin;
                  tri_ready_q <= 1'b0;
                  state_q     <= box_empty_c ? ST_DRAIN : ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (advance_c) begin
                  if (box_end_c) begin
                     state_q <= ST_DRAIN;
                  end else begin
                     cur_x_q <= cur_x_d;
                     cur_y_q <= cur_y_d;
                  end
               end
            end
            ST_DRAIN: begin
               if (!frag_valid_q || accept_c) begin
                  done_q      <= 1'b1;
                  tri_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               tri_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign tri_ready    = tri_ready_q;
   assign samp_pa      = pa_q;
   assign samp_pb      = pb_q;
   assign samp_pc      = pc_q;
   assign samp_winding = winding_q;
   assign frag_valid   = frag_valid_q;
   assign frag_x       = frag_x_q;
   assign frag_y       = frag_y_q;
   assign done         = done_q;

endmodule

// File: tb/tb_raster_traverser.sv
// Directed bench for raster_traverser with a behavioural edge-function sampler.
module tb_raster_traverser;

   localparam int unsigned COORD_W = 10;

   localparam logic [32:0] C0    = 33'h07F800000;  // 0.5
   localparam logic [32:0] C1    = 33'h080400000;  // 1.5
   localparam logic [32:0] C2    = 33'h080A00000;  // 2.5
   localparam logic [32:0] C5    = 33'h081300000;  // 5.5
   localparam logic [32:0] C1023 = 33'h084FFE000;  // 1023.5

   logic               clk = 1'b0;
   logic               rst_n;
   logic               tri_valid;
   logic               tri_ready;
   logic [9:0]         bb_xmin, bb_xmax, bb_ymin, bb_ymax;
   logic [65:0]        tri_pa, tri_pb, tri_pc;
   logic               tri_winding;
   logic [65:0]        samp_pa, samp_pb, samp_pc, samp_p;
   logic               samp_winding;
   logic               samp_inside;
   logic               frag_valid, frag_ready;
   logic [9:0]         frag_x, frag_y;
   logic               done;
   logic [9:0]         conv_n;
   logic [32:0]        conv_rec;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   raster_traverser #(.COORD_W(COORD_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .tri_valid(tri_valid), .tri_ready(tri_ready),
      .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax),
      .tri_pa(tri_pa), .tri_pb(tri_pb), .tri_pc(tri_pc), .tri_winding(tri_winding),
      .samp_pa(samp_pa), .samp_pb(samp_pb), .samp_pc(samp_pc),
      .samp_winding(samp_winding), .samp_p(samp_p), .samp_inside(samp_inside),
      .frag_valid(frag_valid), .frag_ready(frag_ready),
      .frag_x(frag_x), .frag_y(frag_y), .done(done)
   );

   pix_to_recfn #(.COORD_W(COORD_W)) u_conv (.n_i(conv_n), .rec_c_o(conv_rec));

   // ---- recFN helpers and point sampler model ----
   function automatic real rec2real(input logic [32:0] r);
      real m;
      int  e;
      if (r[31:29] == 3'b000) return 0.0;
      e = int'(r[31:23]) - 256;
      m = 1.0 + real'(r[22:0]) / 8388608.0;
      if (e >= 0) for (int i = 0; i < e; i++) m = m * 2.0;
      else        for (int i = 0; i < -e; i++) m = m / 2.0;
      return m;
   endfunction

   function automatic logic [32:0] mk_rec(input int v);
      logic [31:0] uv;
      logic [22:0] f;
      int          p;
      if (v == 0) return 33'd0;
      uv = 32'(v);
      p  = 0;
      for (int i = 0; i < 32; i++) if (uv[i]) p = i;
      f = 23'(uv << (23 - p));
      return {1'b0, 9'(256 + p), f};
   endfunction

   function automatic logic [65:0] pt(input int x, input int y);
      return {mk_rec(x), mk_rec(y)};
   endfunction

   function automatic real edge_fn(input real ax, input real ay, input real bx,
                                   input real by, input real px, input real py);
      return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
   endfunction

   // Strictly-inside test; clockwise (screen y-down) triangles give positive edges
   function automatic logic point_inside(input logic [65:0] a, input logic [65:0] b,
                                         input logic [65:0] c, input logic [65:0] p,
                                         input logic w);
      real ax, ay, bx, by, cx, cy, px, py, e0, e1, e2;
      ax = rec2real(a[65:33]); ay = rec2real(a[32:0]);
      bx = rec2real(b[65:33]); by = rec2real(b[32:0]);
      cx = rec2real(c[65:33]); cy = rec2real(c[32:0]);
      px = rec2real(p[65:33]); py = rec2real(p[32:0]);
      e0 = edge_fn(ax, ay, bx, by, px, py);
      e1 = edge_fn(bx, by, cx, cy, px, py);
      e2 = edge_fn(cx, cy, ax, ay, px, py);
      if (w) return (e0 > 0.0) && (e1 > 0.0) && (e2 > 0.0);
      return (e0 < 0.0) && (e1 < 0.0) && (e2 < 0.0);
   endfunction

   assign samp_inside = point_inside(samp_pa, samp_pb, samp_pc, samp_p, samp_winding);

   // ---- checking ----
   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      int          ax, ay, bx, by, cx, cy;
      logic        wind;
      int          xmin, xmax, ymin, ymax;
      logic        stall;
      int          fstart, nexp;
      logic [65:0] exp_sp;
   } vec_t;

   localparam int NVEC = 7;
   vec_t vecs [NVEC];
   int   fx [8] = '{0, 1, 2, 0, 1, 0, 1023, 2};
   int   fy [8] = '{0, 0, 0, 1, 1, 2, 1023, 0};

   task automatic drive_tri(input vec_t v);
      tri_pa      = pt(v.ax, v.ay);
      tri_pb      = pt(v.bx, v.by);
      tri_pc      = pt(v.cx, v.cy);
      tri_winding = v.wind;
      bb_xmin     = 10'(v.xmin);
      bb_xmax     = 10'(v.xmax);
      bb_ymin     = 10'(v.ymin);
      bb_ymax     = 10'(v.ymax);
      tri_valid   = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " tri_ready"},    66'(tri_ready), 66'(1));
      chk({tag, " frag_valid"},   66'(frag_valid), 66'(0));
      chk({tag, " done"},         66'(done), 66'(0));
      chk({tag, " frag_xy"},      66'({frag_x, frag_y}), 66'(0));
      chk({tag, " samp_pa"},      samp_pa, 66'(0));
      chk({tag, " samp_pb"},      samp_pb, 66'(0));
      chk({tag, " samp_pc"},      samp_pc, 66'(0));
      chk({tag, " samp_winding"}, 66'(samp_winding), 66'(0));
      chk({tag, " samp_p"},       samp_p, 66'(0));
   endtask

   task automatic run_vec(input int idx);
      vec_t       v;
      int         nfrag, cyc;
      logic       got_done, prev_stall;
      logic [9:0] px, py;
      logic [3:0] pat;
      string      tag;
      v   = vecs[idx];
      pat = 4'b1001;  // frag_ready sequence 1,0,0,1 (index 0 first)
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      chk({tag, " tri_ready idle"}, 66'(tri_ready), 66'(1));
      drive_tri(v);
      frag_ready = 1'b1;
      @(posedge clk);
      #1;
      tri_valid = 1'b0;
      chk({tag, " tri_ready busy"}, 66'(tri_ready), 66'(0));
      chk({tag, " samp_pa"}, samp_pa, tri_pa);
      chk({tag, " samp_pc"}, samp_pc, tri_pc);
      chk({tag, " samp_winding"}, 66'(samp_winding), 66'(tri_winding));
      if (v.xmin <= v.xmax && v.ymin <= v.ymax)
         chk({tag, " first samp_p"}, samp_p, v.exp_sp);
      nfrag      = 0;
      cyc        = 0;
      got_done   = 1'b0;
      prev_stall = 1'b0;
      px         = '0;
      py         = '0;
      while (!got_done && cyc < 300) begin
         @(negedge clk);
         frag_ready = v.stall ? pat[2'(cyc)] : 1'b1;
         if (prev_stall) begin
            chk({tag, " hold valid"}, 66'(frag_valid), 66'(1));
            chk({tag, " hold xy"}, 66'({frag_x, frag_y}), 66'({px, py}));
         end
         prev_stall = frag_valid && !frag_ready;
         px = frag_x;
         py = frag_y;
         if (frag_valid && frag_ready) begin
            if (nfrag < v.nexp) begin
               chk($sformatf("%s frag%0d x", tag, nfrag), 66'(frag_x), 66'(fx[v.fstart + nfrag]));
               chk($sformatf("%s frag%0d y", tag, nfrag), 66'(frag_y), 66'(fy[v.fstart + nfrag]));
            end else begin
               chk({tag, " extra frag count"}, 66'(nfrag + 1), 66'(v.nexp));
            end
            nfrag++;
         end
         if (done) begin
            got_done = 1'b1;
            chk({tag, " no frag with done"}, 66'(frag_valid), 66'(0));
         end
         cyc++;
      end
      chk({tag, " done seen"}, 66'(got_done), 66'(1));
      chk({tag, " frag count"}, 66'(nfrag), 66'(v.nexp));
      @(negedge clk);
      chk({tag, " done one cycle"}, 66'(done), 66'(0));
      chk({tag, " tri_ready back"}, 66'(tri_ready), 66'(1));
   endtask

   initial begin : main
      logic [9:0]  cn  [5];
      logic [32:0] ce  [5];
      logic        seen;

      vecs[0] = '{0, 0, 4, 0, 0, 4, 1'b1, 0, 3, 0, 3, 1'b0, 0, 6, {C0, C0}};
      vecs[1] = '{0, 0, 4, 0, 0, 4, 1'b1, 0, 3, 0, 3, 1'b1, 0, 6, {C0, C0}};
      vecs[2] = '{0, 0, 4, 0, 0, 4, 1'b1, 5, 4, 0, 3, 1'b0, 0, 0, 66'd0};
      vecs[3] = '{1000, 1000, 1100, 1000, 1000, 1100, 1'b1, 1023, 1023, 1023, 1023,
                  1'b0, 6, 1, {C1023, C1023}};
      vecs[4] = '{0, 0, 4, 0, 0, 4, 1'b0, 0, 3, 0, 3, 1'b0, 0, 0, {C0, C0}};
      vecs[5] = '{0, 0, 4, 0, 0, 4, 1'b1, 2, 3, 0, 1, 1'b1, 7, 1, {C2, C0}};
      vecs[6] = '{0, 0, 4, 0, 0, 4, 1'b1, 0, 3, 2, 1, 1'b0, 0, 0, 66'd0};

      cn[0] = 10'd0;    ce[0] = C0;
      cn[1] = 10'd1;    ce[1] = C1;
      cn[2] = 10'd2;    ce[2] = C2;
      cn[3] = 10'd5;    ce[3] = C5;
      cn[4] = 10'd1023; ce[4] = C1023;

      rst_n       = 1'b0;
      tri_valid   = 1'b0;
      frag_ready  = 1'b0;
      tri_winding = 1'b0;
      tri_pa      = '0;
      tri_pb      = '0;
      tri_pc      = '0;
      bb_xmin     = '0;
      bb_xmax     = '0;
      bb_ymin     = '0;
      bb_ymax     = '0;
      conv_n      = '0;

      #12;
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         conv_n = cn[i];
         #1;
         chk($sformatf("conv n=%0d", cn[i]), 66'(conv_rec), 66'(ce[i]));
      end

      for (int i = 0; i < NVEC; i++) run_vec(i);

      // Reset in the middle of a stalled scan must abandon the triangle
      @(negedge clk);
      drive_tri(vecs[0]);
      frag_ready = 1'b0;
      @(posedge clk);
      #1;
      tri_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre-reset stalled valid", 66'(frag_valid), 66'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid");
      repeat (2) @(negedge clk);
      rst_n      = 1'b1;
      frag_ready = 1'b1;
      seen       = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("no done after abort", 66'(seen), 66'(0));
      run_vec(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
